// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: two-state fetch/decode sequencer holding PC, IR and a saturating taken-branch count
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_read,
  output logic [15:0] mem_address,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc_out,
  input  logic [15:0] br_add_out,
  input  logic [2:0]  cc,
  input  logic        stall,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  output logic [15:0] taken_count
);
  typedef enum logic {FETCH, DECODE} state_t;
  state_t state, state_nx;
  logic capture, exit_dec, taken;
  assign mem_address = pc_out;
  assign taken = (ir_out[15:12] == 4'b0000) && |(ir_out[11:9] & cc);
  // next state and request: capture ends a fetch, an unstalled decode cycle ends a decode
  always_comb begin
    mem_read = (state == FETCH);
    capture  = (state == FETCH) && mem_resp;
    exit_dec = (state == DECODE) && !stall;
    state_nx = capture ? DECODE : exit_dec ? FETCH : state;
  end
  // state, PC, IR and branch counter; cc/br_add_out only matter on decode exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc_out      <= {RESET_PC[15:1], 1'b0};
      ir_out      <= 16'h0000;
      ir_valid    <= 1'b0;
      taken_count <= 16'h0000;
    end else begin
      state    <= state_nx;
      ir_valid <= capture;
      if (capture) begin
        ir_out <= mem_rdata;
        pc_out <= pc_out + 16'd2;
      end else if (exit_dec && taken) begin
        pc_out      <= {br_add_out[15:1], 1'b0};
        taken_count <= (&taken_count) ? taken_count : taken_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench with an instruction scoreboard
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_read, mem_resp = 1'b0, stall = 1'b0, ir_valid;
  logic [15:0] mem_address, mem_rdata = 16'h0, pc_out, br_add_out = 16'h0, ir_out, taken_count;
  logic [2:0] cc = 3'b000;
  logic mem_read2, mem_resp2 = 1'b0, ir_valid2;
  logic [15:0] mem_address2, pc_out2, ir_out2, taken_count2;
  int tests = 0, fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_tc = 16'h0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_address(mem_address),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pc_out(pc_out), .br_add_out(br_add_out),
    .cc(cc), .stall(stall), .ir_out(ir_out), .ir_valid(ir_valid), .taken_count(taken_count)
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read2), .mem_address(mem_address2),
    .mem_resp(mem_resp2), .mem_rdata(16'h1000), .pc_out(pc_out2), .br_add_out(16'h0000),
    .cc(3'b000), .stall(1'b0), .ir_out(ir_out2), .ir_valid(ir_valid2), .taken_count(taken_count2)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [15:0] instr, input int waits, input int stalls,
                          input logic [2:0] c, input logic [15:0] br);
    logic [15:0] a, exp_ir, exp_pc;
    logic tk;
    a = pc_out;
    check("fetch_mem_read", {15'h0, mem_read}, 16'h1);
    check("fetch_addr", mem_address, a);
    for (int i = 0; i < waits; i++) begin
      mem_resp = 1'b0;
      mem_rdata = 16'($urandom);
      tick();
      check("wait_mem_read", {15'h0, mem_read}, 16'h1);
      check("wait_addr", mem_address, a);
      check("wait_ir_valid", {15'h0, ir_valid}, 16'h0);
    end
    mem_resp = 1'b1;
    mem_rdata = instr;
    exp_q.push_back(instr);
    tick();
    check("dec_ir_valid", {15'h0, ir_valid}, 16'h1);
    exp_ir = exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx;
    check("dec_ir_out", ir_out, exp_ir);
    check("dec_pc", pc_out, a + 16'd2);
    check("dec_mem_read", {15'h0, mem_read}, 16'h0);
    mem_rdata = 16'hBEEF;
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      cc = 3'b111;
      br_add_out = 16'h5554;
      tick();
      check("stall_ir_valid", {15'h0, ir_valid}, 16'h0);
      check("stall_mem_read", {15'h0, mem_read}, 16'h0);
      check("stall_pc", pc_out, a + 16'd2);
    end
    stall = 1'b0;
    cc = c;
    br_add_out = br;
    tk = (instr[15:12] == 4'b0000) && |(instr[11:9] & c);
    exp_pc = tk ? {br[15:1], 1'b0} : a + 16'd2;
    if (tk && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
    tick();
    mem_resp = 1'b0;
    check("exit_pc", pc_out, exp_pc);
    check("exit_taken_count", taken_count, m_tc);
    check("exit_ir_hold", ir_out, instr);
    check("exit_ir_valid", {15'h0, ir_valid}, 16'h0);
  endtask

  initial begin
    tick();
    check("rst_pc", pc_out, 16'h0000);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_ir_valid", {15'h0, ir_valid}, 16'h0);
    check("rst_taken", taken_count, 16'h0000);
    check("rst_mem_read", {15'h0, mem_read}, 16'h1);
    check("rst_pc2", pc_out2, 16'hFFFE);
    tick();
    rst_n = 1'b1;
    mem_resp2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_instr(16'h1000, 0, 0, 3'b000, 16'h0000);
      if (i == 0) begin
        check("wrap_pc2", pc_out2, 16'h0000);
        mem_resp2 = 1'b0;
      end
    end
    check("pc_after_3", pc_out, 16'h0006);
    check("taken_after_3", taken_count, 16'h0000);
    for (int i = 0; i < 5; i++) do_instr(16'h1000, 0, 0, 3'b111, 16'h3332);
    check("pc_at_10", pc_out, 16'h0010);
    do_instr(16'h0E05, 0, 0, 3'b010, 16'h001C);
    check("br_taken_pc", pc_out, 16'h001C);
    check("br_taken_count", taken_count, 16'h0001);
    do_instr(16'h0805, 0, 0, 3'b001, 16'h0040);
    check("brn_not_taken_pc", pc_out, 16'h001E);
    do_instr(16'h0000, 0, 0, 3'b111, 16'h0040);
    check("br_never_pc", pc_out, 16'h0020);
    do_instr(16'h1000, 3, 2, 3'b111, 16'h0000);
    do_instr(16'h0201, 1, 1, 3'b001, 16'h4567);
    check("odd_target_pc", pc_out, 16'h4566);
    do_instr(16'h0E00, 0, 0, 3'b100, 16'hFFFF);
    check("wrap_target_pc", pc_out, 16'hFFFE);
    do_instr(16'h1000, 0, 0, 3'b000, 16'h0000);
    check("pc_wrap", pc_out, 16'h0000);
    force dut.taken_count = 16'hFFFF;
    #1;
    release dut.taken_count;
    m_tc = 16'hFFFF;
    check("preload_taken", taken_count, 16'hFFFF);
    do_instr(16'h0E00, 0, 1, 3'b010, 16'h0100);
    check("sat_taken", taken_count, 16'hFFFF);
    do_instr(16'h1000, 0, 0, 3'b000, 16'h0000);
    mem_resp = 1'b0;
    tick();
    check("pend_mem_read", {15'h0, mem_read}, 16'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc_out, 16'h0000);
    check("async_ir_valid", {15'h0, ir_valid}, 16'h0);
    check("async_ir", ir_out, 16'h0000);
    check("async_taken", taken_count, 16'h0000);
    m_tc = 16'h0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_mem_read", {15'h0, mem_read}, 16'h1);
    check("post_rst_addr", mem_address, 16'h0000);
    do_instr(16'h0E02, 2, 0, 3'b100, 16'h0006);
    check("post_rst_branch", pc_out, 16'h0006);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
